mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core datapath.
- Steps every instruction through fetch, decode, execute, memory and writeback states.
- Drives PC/IR/register-file/memory strobes and datapath mux selects from the decoded opcode/funct and the ALU zero flag.
- Inserts a parameterised number of wait cycles on every memory access, so instruction fetch and data access can share one memory port.

Parameters:
- MEM_LATENCY, 2, cycles per memory access (instruction or data); legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  asynchronous active-low reset
- opcode  in  6  inst[31:26] from IR; stable from DECODE onward
- funct  in  6  inst[5:0] from IR
- zero  in  1  ALU zero flag, sampled in EXEC
- stall  in  1  freeze request (debug / external hold)
- inst_req  out  1  memory port owned by fetch (address = PC)
- mem_req  out  1  memory port owned by data access (address = ALU result)
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- alu_src  out  1  0 rt data, 1 sign-extended immediate
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 immediate-op-decoded
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC (link)
- reg_we  out  1  register file write strobe
- mem_write_en  out  1  data store strobe
- halted  out  1  sticky halt indication
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  3  debug: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT

Behaviour:
- Reset (async, rst_b=0):
  - state=FETCH, wait counter cnt=0, halted=0.
  - Outputs are the FETCH/cnt=0 values: inst_req=1, all other outputs 0.
- Instruction classes:
  - R: opcode 0x00, funct != 0x0C.
  - SYSCALL: opcode 0x00, funct 0x0C.
  - LW 0x23; SW 0x2B; BEQ 0x04; BNE 0x05; J 0x02; JAL 0x03.
  - IALU: 0x08–0x0F.
  - Everything else is illegal.
- FETCH:
  - inst_req=1 for MEM_LATENCY cycles; cnt counts 0..MEM_LATENCY-1.
  - On cnt==MEM_LATENCY-1: ir_we=1, cnt←0, next DECODE.
- DECODE (1 cycle):
  - SYSCALL: pc_we=0, next HALT.
  - Illegal: illegal=1, pc_we=1, pc_src=00, next FETCH.
  - Otherwise: pc_we=1, pc_src=00 (PC+4 committed), next EXEC.
- EXEC (1 cycle):
  - R: alu_src=0, alu_op=10 → WB.
  - IALU: alu_src=1, alu_op=11 → WB.
  - LW/SW: alu_src=1, alu_op=00 → MEM.
  - BEQ/BNE: alu_src=0, alu_op=01; branch taken iff zero==1 (BEQ) or zero==0 (BNE).
    - Taken: pc_we=1, pc_src=01.
    - Next FETCH either way.
  - J: pc_we=1, pc_src=10 → FETCH.
  - JAL: pc_we=1, pc_src=10 → WB.
- MEM:
  - mem_req=1 for MEM_LATENCY cycles; alu_src/alu_op held as in EXEC.
  - SW: mem_write_en=1 on cnt==0 only; after last cycle → FETCH.
  - LW: after last cycle → WB.
- WB (1 cycle), reg_we=1:
  - R: reg_dst=01, wb_sel=00.
  - IALU: reg_dst=00, wb_sel=00.
  - LW: reg_dst=00, wb_sel=01.
  - JAL: reg_dst=10, wb_sel=10 (link = PC already incremented in DECODE).
  - Next FETCH.
- HALT:
  - halted=1, all strobes 0, terminal until reset.
  - stall has no effect in HALT.
- Latency, with L = MEM_LATENCY:
  - R/IALU: L+3
  - LW: 2L+3
  - SW: 2L+2
  - BEQ/BNE/J: L+2
  - JAL: L+3
  - SYSCALL: L+1 cycles to reach HALT.
- stall=1:
  - state and cnt hold.
  - pc_we, ir_we, reg_we, mem_write_en and illegal forced 0.
  - inst_req/mem_req and mux selects keep their state values.
  - On release, the interrupted state resumes at the held cnt.
  - A SW whose write cycle was stalled issues mem_write_en once, after release.
- Outputs are combinational from registered state/cnt plus opcode, funct and zero. There are no glitch requirements beyond synchronous sampling.
- Reset mid-operation: immediate return to reset values. No partial writes are issued after rst_b falls.
- MEM_LATENCY=1: cnt is constantly 0; FETCH and MEM each take exactly one cycle.

Test Plan:
- Reset release, MEM_LATENCY=2, opcode=0x00/funct=0x20 → state 0,0,1,2,4,0 on successive cycles; ir_we on cycle 2, pc_we on 3, reg_we with reg_dst=01 on 5.
- LW (0x23), L=2 → mem_req high for exactly 2 cycles in MEM; WB with wb_sel=01, reg_dst=00; 7 cycles total. SW (0x2B) → single mem_write_en pulse, no reg_we, 6 cycles.
- BEQ with zero=1 → EXEC pc_we=1, pc_src=01. BEQ with zero=0 → no pc_we in EXEC. BNE mirrors both cases.
- JAL (0x03) → EXEC pc_src=10 pc_we=1, then WB reg_dst=10, wb_sel=10, reg_we=1.
- SYSCALL (opcode 0, funct 0x0C) → HALT after 3 cycles, halted=1 sticky for ≥20 cycles with no strobes. Opcode 0x3F → single illegal pulse, PC+4, back to FETCH.
- SW with stall=1 held across MEM cnt 0 for 5 cycles → zero write strobes during stall, exactly one after release. rst_b=0 asserted mid-MEM → state=0 and halted=0 asynchronously.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath strobes and selects.
//
// state  | meaning
// FETCH  | shared memory port reads instruction at PC for MEM_LATENCY cycles
// DECODE | classify IR, commit PC+4 (or halt on SYSCALL)
// EXEC   | ALU operation, branch/jump resolution
// MEM    | shared memory port performs LW/SW for MEM_LATENCY cycles
// WB     | register file write
// HALT   | terminal after SYSCALL, left only through reset
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       stall,
  output logic       inst_req,
  output logic       mem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       reg_we,
  output logic       mem_write_en,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_SYSCALL, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_IALU, C_ILLEGAL
  } iclass_t;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  iclass_t    iclass;
  logic       last_cycle;
  logic       commit;
  logic       ir_we_raw, pc_we_raw, reg_we_raw, mem_we_raw, illegal_raw;

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      6'h00: iclass = (funct == 6'h0C) ? C_SYSCALL : C_R;
      6'h23: iclass = C_LW;
      6'h2B: iclass = C_SW;
      6'h04: iclass = C_BEQ;
      6'h05: iclass = C_BNE;
      6'h02: iclass = C_J;
      6'h03: iclass = C_JAL;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: iclass = C_IALU;
      default: iclass = C_ILLEGAL;
    endcase
  end

  assign last_cycle = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else if (!stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inst_req    = 1'b0;
    mem_req     = 1'b0;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    pc_src      = 2'b00;
    alu_src     = 1'b0;
    alu_op      = 2'b00;
    reg_dst     = 2'b00;
    wb_sel      = 2'b00;
    reg_we_raw  = 1'b0;
    mem_we_raw  = 1'b0;
    illegal_raw = 1'b0;

    case (state_q)
      S_FETCH: begin
        inst_req = 1'b1;
        if (last_cycle) begin
          ir_we_raw = 1'b1;
          cnt_d     = 4'd0;
          state_d   = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DECODE: begin
        case (iclass)
          C_SYSCALL: state_d = S_HALT;
          C_ILLEGAL: begin
            illegal_raw = 1'b1;
            pc_we_raw   = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            pc_we_raw = 1'b1;
            state_d   = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (iclass)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_IALU: begin
            alu_src = 1'b1;
            alu_op  = 2'b11;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            cnt_d   = 4'd0;
            state_d = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_op = 2'b01;
            if ((iclass == C_BEQ) == zero) begin
              pc_we_raw = 1'b1;
              pc_src    = 2'b01;
            end
          end
          C_J: begin
            pc_we_raw = 1'b1;
            pc_src    = 2'b10;
          end
          C_JAL: begin
            pc_we_raw = 1'b1;
            pc_src    = 2'b10;
            state_d   = S_WB;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req    = 1'b1;
        alu_src    = 1'b1;
        // a stalled write cycle keeps cnt at 0, so the strobe fires once on release
        mem_we_raw = (iclass == C_SW) && (cnt_q == 4'd0);
        if (last_cycle) begin
          cnt_d   = 4'd0;
          state_d = (iclass == C_LW) ? S_WB : S_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WB: begin
        reg_we_raw = 1'b1;
        state_d    = S_FETCH;
        case (iclass)
          C_R:   reg_dst = 2'b01;
          C_LW:  wb_sel  = 2'b01;
          C_JAL: begin
            reg_dst = 2'b10;
            wb_sel  = 2'b10;
          end
          default: begin
            reg_dst = 2'b00;
            wb_sel  = 2'b00;
          end
        endcase
      end

      S_HALT: state_d = S_HALT;

      default: begin
        state_d = S_FETCH;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Write strobes are suppressed while stalled or while reset is asserted.
  assign commit       = rst_b & ~stall;
  assign ir_we        = ir_we_raw   & commit;
  assign pc_we        = pc_we_raw   & commit;
  assign reg_we       = reg_we_raw  & commit;
  assign mem_write_en = mem_we_raw  & commit;
  assign illegal      = illegal_raw & commit;
  assign halted       = (state_q == S_HALT);
  assign state        = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: per-instruction expected output traces are built from the
// instruction-class rules and queued; a negedge monitor compares every cycle.
module tb_mips_multicycle_ctrl;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [5:0] opcode, funct;
  logic       zero, stall;
  logic       inst_req, mem_req, ir_we, pc_we, alu_src, reg_we, mem_write_en, halted, illegal;
  logic [1:0] pc_src, alu_op, reg_dst, wb_sel;
  logic [2:0] state;

  mips_multicycle_ctrl #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
    .inst_req(inst_req), .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst), .wb_sel(wb_sel), .reg_we(reg_we),
    .mem_write_en(mem_write_en), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       inst_req, mem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] alu_op, reg_dst, wb_sel;
    logic       reg_we, mem_write_en, halted, illegal;
  } rec_t;

  rec_t q[$];
  rec_t trace[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(negedge clk) begin : monitor
    rec_t e, g;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{state, inst_req, mem_req, ir_we, pc_we, pc_src, alu_src, alu_op,
            reg_dst, wb_sel, reg_we, mem_write_en, halted, illegal};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d op=%h fn=%h z=%b stall=%b: got st=%0d vec=%h, expected st=%0d vec=%h",
                 cyc, opcode, funct, zero, stall, g.st, g, e.st, e);
      end
    end
  end

  function automatic rec_t masked(input rec_t r);
    rec_t m = r;
    m.ir_we = 1'b0; m.pc_we = 1'b0; m.reg_we = 1'b0; m.mem_write_en = 1'b0; m.illegal = 1'b0;
    return m;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h05) || (op == 6'h02) || (op == 6'h03) || (op >= 6'h08 && op <= 6'h0F);
  endfunction

  // Expected cycle-by-cycle outputs of one instruction, no stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, output bit halts);
    rec_t r;
    bit sc, is_r, lw, sw, beq, bne, j, jal, ialu, ill;
    sc   = (op == 6'h00) && (fn == 6'h0C);
    is_r = (op == 6'h00) && !sc;
    lw   = (op == 6'h23);
    sw   = (op == 6'h2B);
    beq  = (op == 6'h04);
    bne  = (op == 6'h05);
    j    = (op == 6'h02);
    jal  = (op == 6'h03);
    ialu = (op >= 6'h08) && (op <= 6'h0F);
    ill  = !legal_op(op);
    trace.delete();
    halts = 1'b0;
    for (int i = 0; i < L; i++) begin
      r = '0; r.st = 3'd0; r.inst_req = 1'b1; r.ir_we = (i == L - 1);
      trace.push_back(r);
    end
    r = '0; r.st = 3'd1; r.pc_we = !sc; r.illegal = ill;
    trace.push_back(r);
    if (sc) begin halts = 1'b1; return; end
    if (ill) return;
    r = '0; r.st = 3'd2;
    if (is_r) r.alu_op = 2'b10;
    if (ialu) begin r.alu_src = 1'b1; r.alu_op = 2'b11; end
    if (lw || sw) r.alu_src = 1'b1;
    if (beq || bne) begin
      r.alu_op = 2'b01;
      if ((beq && z) || (bne && !z)) begin r.pc_we = 1'b1; r.pc_src = 2'b01; end
    end
    if (j || jal) begin r.pc_we = 1'b1; r.pc_src = 2'b10; end
    trace.push_back(r);
    if (lw || sw)
      for (int i = 0; i < L; i++) begin
        r = '0; r.st = 3'd3; r.mem_req = 1'b1; r.alu_src = 1'b1; r.mem_write_en = sw && (i == 0);
        trace.push_back(r);
      end
    if (is_r || ialu || lw || jal) begin
      r = '0; r.st = 3'd4; r.reg_we = 1'b1;
      if (is_r) r.reg_dst = 2'b01;
      if (lw) r.wb_sel = 2'b01;
      if (jal) begin r.reg_dst = 2'b10; r.wb_sel = 2'b10; end
      trace.push_back(r);
    end
  endtask

  task automatic step(input rec_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int pct, input int st_idx, input int st_len);
    bit h;
    int idx = 0, held = 0;
    rec_t r;
    build(op, fn, z, h);
    opcode = op; funct = fn; zero = z;
    while (trace.size() > 0) begin
      if (idx == st_idx && held < st_len) begin
        stall = 1'b1; held++;
      end else begin
        stall = ($urandom_range(0, 99) < pct);
      end
      if (stall) step(masked(trace[0]));
      else begin
        r = trace.pop_front();
        idx++;
        step(r);
      end
    end
    stall = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    rec_t r;
    r = '0; r.st = 3'd5; r.halted = 1'b1;
    repeat (n) begin
      stall = ($urandom_range(0, 99) < 30);
      step(r);
    end
    stall = 1'b0;
  endtask

  // Drops reset part-way into the current cycle; outputs must follow at once.
  task automatic do_reset(input int n);
    rec_t r;
    r = '0; r.st = 3'd0; r.inst_req = 1'b1;
    q.push_back(r);
    #1 rst_b = 1'b0;
    @(posedge clk); #1;
    repeat (n - 1) step(r);
    rst_b = 1'b1;
  endtask

  task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
    int k = $urandom_range(0, 9);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0: begin op = 6'h00; while (fn == 6'h0C) fn = 6'($urandom_range(0, 63)); end
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h05;
      5: op = 6'h02;
      6: op = 6'h03;
      7, 8: op = 6'($urandom_range(8, 15));
      default: begin
        op = 6'($urandom_range(0, 63));
        while (legal_op(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [5:0] op, fn;
    rec_t r, rr;
    bit h;
    rst_b = 1'b0; stall = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    rr = '0; rr.inst_req = 1'b1;
    @(posedge clk); #1;
    repeat (3) step(rr);
    rst_b = 1'b1;

    run_instr(6'h00, 6'h20, 1'b0, 0, -1, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0, -1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h05, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, -1, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h0D, 6'h00, 1'b0, 0, -1, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, -1, 0);

    for (int n = 0; n < 200; n++) begin
      rand_instr(op, fn);
      run_instr(op, fn, 1'($urandom_range(0, 1)), 20, -1, 0);
    end

    // SW held at its write cycle (MEM cnt 0) for 5 cycles
    run_instr(6'h2B, 6'h00, 1'b0, 0, L + 2, 5);

    run_instr(6'h00, 6'h0C, 1'b0, 0, -1, 0);
    halt_cycles(25);
    do_reset(2);

    // SW aborted by reset at its write cycle
    build(6'h2B, 6'h00, 1'b0, h);
    opcode = 6'h2B; funct = 6'h00;
    for (int i = 0; i < L + 2; i++) begin
      r = trace.pop_front();
      step(r);
    end
    do_reset(3);

    run_instr(6'h00, 6'h25, 1'b0, 0, -1, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records never compared", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
